fp_divider: RTL



---
 rtl/fp_divider.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fp_divider.sv
// rtl/fp_divider.sv - iterative restoring floating-point divider
//
// Computes a_in / b_in for a sign / EXP_WIDTH-bit biased exponent /
// MANTISSA_WIDTH-bit fraction format, one quotient bit per clock.
// Ports:
//   clk_in, rst_in      clock (rising edge), synchronous active-high reset
//   start_in            request, accepted when start_in && ready_out
//   a_in, b_in          dividend, divisor
//   ready_out           high while idle (also in the valid_out cycle)
//   valid_out           one-cycle pulse, fpd_out and flags are valid
//   fpd_out             quotient, truncated
//   overflow_out        exponent overflow, result saturated to infinity
//   underflow_out       exponent underflow, result flushed to zero
//   div_by_zero_out     divisor magnitude is zero
module fp_divider #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  start_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     a_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]     b_in,
  output logic                                  ready_out,
  output logic                                  valid_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]     fpd_out,
  output logic                                  overflow_out,
  output logic                                  underflow_out,
  output logic                                  div_by_zero_out
);

  localparam int W    = EXP_WIDTH + MANTISSA_WIDTH + 1;
  localparam int M    = MANTISSA_WIDTH;
  localparam int E    = EXP_WIDTH;
  localparam int CW   = $clog2(M + 2);
  localparam int BIAS = 2 ** (E - 1) - 1;
  localparam logic [E+1:0] BIAS_X = (E + 2)'(BIAS);
  localparam logic [E+1:0] EMAX_X = (E + 2)'(2 ** E - 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(M + 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic [M+1:0]  rem_q;
  logic [M+1:0]  quo_q;
  logic [CW-1:0] cnt_q;

  logic [E-1:0]  a_exp, b_exp;
  logic          a_zero, b_zero;
  logic [M+1:0]  mb_ext;
  logic          rem_ge;
  logic [M+1:0]  rem_sub;
  logic          q_msb;
  logic [M-1:0]  norm_frac;
  logic [E+1:0]  exp_calc;
  logic          exp_ovf, exp_unf;
  logic          res_sign;

  always_comb begin
    a_exp    = a_q[W-2:M];
    b_exp    = b_q[W-2:M];
    a_zero   = (a_q[W-2:0] == '0);
    b_zero   = (b_q[W-2:0] == '0);
    mb_ext   = {1'b0, ~b_zero, b_q[M-1:0]};
    // One restoring step: subtract the divisor when it fits.
    rem_ge   = (rem_q >= mb_ext);
    rem_sub  = rem_ge ? (rem_q - mb_ext) : rem_q;
    // Quotient lies in (1/2, 2); the top bit selects the normalising shift.
    q_msb     = quo_q[M+1];
    norm_frac = q_msb ? quo_q[M:1] : quo_q[M-1:0];
    exp_calc  = {2'b00, a_exp} - {2'b00, b_exp} + BIAS_X
                - {{(E+1){1'b0}}, ~q_msb};
    exp_ovf   = ($signed(exp_calc) >= $signed(EMAX_X));
    exp_unf   = exp_calc[E+1] || (exp_calc == '0);
    res_sign  = a_q[W-1] ^ b_q[W-1];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      ready_out       <= 1'b1;
      valid_out       <= 1'b0;
      fpd_out         <= '0;
      overflow_out    <= 1'b0;
      underflow_out   <= 1'b0;
      div_by_zero_out <= 1'b0;
      a_q             <= '0;
      b_q             <= '0;
      rem_q           <= '0;
      quo_q           <= '0;
      cnt_q           <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_q       <= a_in;
            b_q       <= b_in;
            // Partial remainder starts as the dividend mantissa with hidden bit.
            rem_q     <= {1'b0, (a_in[W-2:0] != '0), a_in[M-1:0]};
            quo_q     <= '0;
            cnt_q     <= '0;
            ready_out <= 1'b0;
            state     <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q <= {rem_sub[M:0], 1'b0};
          quo_q <= {quo_q[M:0], rem_ge};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state <= NORM;
          end
        end
        NORM: begin
          valid_out <= 1'b1;
          ready_out <= 1'b1;
          state     <= IDLE;
          if (b_zero) begin
            fpd_out         <= {res_sign, {E{1'b1}}, {M{1'b0}}};
            div_by_zero_out <= 1'b1;
            overflow_out    <= 1'b0;
            underflow_out   <= 1'b0;
          end else if (a_zero) begin
            fpd_out         <= {res_sign, {(W-1){1'b0}}};
            div_by_zero_out <= 1'b0;
            overflow_out    <= 1'b0;
            underflow_out   <= 1'b0;
          end else begin
            div_by_zero_out <= 1'b0;
            overflow_out    <= exp_ovf;
            underflow_out   <= exp_unf && !exp_ovf;
            if (exp_ovf) begin
              fpd_out <= {res_sign, {E{1'b1}}, {M{1'b0}}};
            end else if (exp_unf) begin
              fpd_out <= {res_sign, {(W-1){1'b0}}};
            end else begin
              fpd_out <= {res_sign, exp_calc[E-1:0], norm_frac};
            end
          end
        end
        default: begin
          state     <= IDLE;
          ready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
